laji_fetch_stage: RTL and testbench

- Instruction-fetch stage (stage 0) of the pipelined CPU.
- Owns the PC, issues addresses to a synchronous instruction memory with 1-cycle read latency, and buffers returned instructions.
- Presents {pc, pc+4, inst} to the IF/ID pipeline register through a valid/ready handshake; out_ready is driven by the IF/ID register enable.
- Accepts branch/jump redirects from later stages and a halt request from decode.

---
 rtl/laji_fetch_pkg.sv | 19 +
 rtl/laji_fetch_buf.sv | 80 ++++++++
 rtl/laji_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_laji_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/laji_fetch_pkg.sv
// Shared types and constants for the laji instruction-fetch stage.
package laji_fetch_pkg;

    localparam int          DEF_PC_WIDTH   = 32;
    localparam int          DEF_INST_WIDTH = 32;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam int          INST_BYTES     = 4;

    typedef struct packed {
        logic [DEF_PC_WIDTH-1:0]   pc;
        logic [DEF_INST_WIDTH-1:0] inst;
    } fetch_bundle_t;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/laji_fetch_buf.sv
// Two-entry {pc, inst} FIFO with the head at entry 0; pop shifts entry 1 down.
module laji_fetch_buf #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [PC_WIDTH-1:0]   push_pc_i,
    input  logic [INST_WIDTH-1:0] push_inst_i,
    output logic [1:0]            count_o,
    output logic [PC_WIDTH-1:0]   head_pc_o,
    output logic [INST_WIDTH-1:0] head_inst_o
);

    logic [PC_WIDTH-1:0]   pc_q   [2];
    logic [PC_WIDTH-1:0]   pc_d   [2];
    logic [INST_WIDTH-1:0] inst_q [2];
    logic [INST_WIDTH-1:0] inst_d [2];
    logic [1:0]            count_q;
    logic [1:0]            count_d;

    // Next-state: flush wins; push to a full buffer or pop from an empty one is ignored.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        pc_d[0] = push_pc_i;  inst_d[0] = push_inst_i;  count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        pc_d[1] = push_pc_i;  inst_d[1] = push_inst_i;  count_d = 2'd2;
                    end else begin
                        count_d = count_q;
                    end
                end
                2'b01: begin
                    if (count_q != 2'd0) begin
                        pc_d[0] = pc_q[1];  inst_d[0] = inst_q[1];  count_d = count_q - 2'd1;
                    end else begin
                        count_d = count_q;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        pc_d[0] = pc_q[1];    inst_d[0] = inst_q[1];
                        pc_d[1] = push_pc_i;  inst_d[1] = push_inst_i;
                    end else begin
                        pc_d[0] = push_pc_i;  inst_d[0] = push_inst_i;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end

    assign count_o     = count_q;
    assign head_pc_o   = pc_q[0];
    assign head_inst_o = inst_q[0];

endmodule

// File: rtl/laji_fetch_stage.sv
// Instruction-fetch stage: PC and issue control, response bypass/buffering,
// redirect flush and sticky halt.
module laji_fetch_stage
    import laji_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH   = DEF_PC_WIDTH,
    parameter int                  INST_WIDTH = DEF_INST_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEF_RESET_PC),
    parameter int                  BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [PC_WIDTH-1:0]   imem_addr,
    output logic                  imem_rd,
    input  logic [INST_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    input  logic                  halt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [PC_WIDTH-1:0]   out_pc_plus4,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  halted
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
    logic                  inflight_q, inflight_d;
    fetch_state_e          state_q, state_d;

    logic [CNT_W-1:0]      buf_count_s;
    logic [PC_WIDTH-1:0]   head_pc_s;
    logic [INST_WIDTH-1:0] head_inst_s;
    logic                  push_s, pop_s;
    logic [PC_WIDTH-1:0]   target_s, addr_s, pc_s;
    logic [INST_WIDTH-1:0] inst_s;
    logic                  valid_s, deq_s, issue_ok_s, issue_s;

    laji_fetch_buf #(.PC_WIDTH(PC_WIDTH), .INST_WIDTH(INST_WIDTH)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .flush_i     (redirect_valid),
        .push_pc_i   (inflight_pc_q),
        .push_inst_i (imem_data),
        .count_o     (buf_count_s),
        .head_pc_o   (head_pc_s),
        .head_inst_o (head_inst_s)
    );

    // Output select, issue decision and buffer control.
    always_comb begin
        target_s   = redirect_pc & ~PC_WIDTH'(3);
        valid_s    = 1'b0;
        pc_s       = '0;
        inst_s     = '0;
        issue_ok_s = en & (state_q == ST_RUN) & ~halt;
        if (redirect_valid) begin
            valid_s = 1'b0;
        end else if (buf_count_s != '0) begin
            valid_s = 1'b1;  pc_s = head_pc_s;      inst_s = head_inst_s;
        end else if (inflight_q) begin
            valid_s = 1'b1;  pc_s = inflight_pc_q;  inst_s = imem_data;
        end else begin
            valid_s = 1'b0;
        end
        deq_s = valid_s & out_ready;
        // Redirect treats buffer and in-flight read as already gone.
        if (redirect_valid) begin
            addr_s  = target_s;
            issue_s = issue_ok_s;
            push_s  = 1'b0;
            pop_s   = 1'b0;
        end else begin
            addr_s  = fetch_pc_q;
            issue_s = issue_ok_s &
                      (({1'b0, buf_count_s} + {{CNT_W{1'b0}}, inflight_q}) <=
                       ((CNT_W+1)'(1) + {{CNT_W{1'b0}}, deq_s}));
            push_s  = inflight_q & ~(deq_s & (buf_count_s == '0));
            pop_s   = deq_s & (buf_count_s != '0);
        end
    end

    // Next PC, in-flight tracking and halt FSM.
    always_comb begin
        inflight_d    = issue_s;
        inflight_pc_d = inflight_pc_q;
        fetch_pc_d    = fetch_pc_q;
        if (issue_s) begin
            inflight_pc_d = addr_s;
            fetch_pc_d    = addr_s + PC_WIDTH'(INST_BYTES);
        end else if (redirect_valid) begin
            fetch_pc_d = target_s;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        case (state_q)
            ST_RUN:    state_d = halt ? ST_HALTED : ST_RUN;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Stage state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            state_q       <= ST_RUN;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            state_q       <= state_d;
        end
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        if (rst) begin
            imem_addr    = '0;
            imem_rd      = 1'b0;
            out_valid    = 1'b0;
            out_pc       = '0;
            out_pc_plus4 = '0;
            out_inst     = '0;
            halted       = 1'b0;
        end else begin
            imem_addr    = addr_s;
            imem_rd      = issue_s;
            out_valid    = valid_s;
            out_pc       = pc_s;
            out_pc_plus4 = pc_s + PC_WIDTH'(INST_BYTES);
            out_inst     = inst_s;
            halted       = (state_q == ST_HALTED);
        end
    end

endmodule

// File: tb/tb_laji_fetch_stage.sv
// Self-checking bench for laji_fetch_stage: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_laji_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, en, redirect_valid, halt, out_ready;
    logic [31:0] redirect_pc, imem_data, imem_addr, out_pc, out_pc_plus4, out_inst;
    logic        imem_rd, out_valid, halted;

    logic [31:0] w_imem_addr, w_out_pc, w_out_pc_plus4, w_out_inst;
    logic        w_imem_rd, w_out_valid, w_halted;
    logic [31:0] w_data = 32'h0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_redirect = 1'b0;
    logic        w_halt = 1'b0;
    logic        w_ready = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    laji_fetch_stage dut (
        .clk(clk), .rst(rst), .en(en), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4), .out_inst(out_inst), .halted(halted)
    );

    laji_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .en(en), .imem_addr(w_imem_addr), .imem_rd(w_imem_rd),
        .imem_data(w_data), .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .halt(w_halt), .out_valid(w_out_valid), .out_ready(w_ready), .out_pc(w_out_pc),
        .out_pc_plus4(w_out_pc_plus4), .out_inst(w_out_inst), .halted(w_halted)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a >> 2) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction memory: one-cycle latency, junk when no read was issued.
    logic        mem_rd_n   = 1'b0;
    logic [31:0] mem_addr_n = 32'h0;
    always @(posedge clk) imem_data <= mem_rd_n ? memf(mem_addr_n) : $urandom;

    // Reference model: every issued-but-undelivered pc in order, in one queue.
    logic [31:0] m_q[$];
    logic [31:0] m_fetch  = 32'h0;
    bit          m_halted = 1'b0;

    always @(negedge clk) begin
        logic [31:0] tgt, e_addr;
        bit          e_valid, e_rd, e_deq;
        if (rst) begin
            chk("rst_valid", {31'h0, out_valid}, 32'h0);
            chk("rst_rd", {31'h0, imem_rd}, 32'h0);
            chk("rst_halted", {31'h0, halted}, 32'h0);
            chk("rst_pc", out_pc, 32'h0);
            chk("rst_addr", imem_addr, 32'h0);
            m_q.delete();
            m_fetch  = 32'h0;
            m_halted = 1'b0;
        end else begin
            tgt = redirect_pc & 32'hFFFF_FFFC;
            if (redirect_valid) begin
                e_valid = 1'b0;
                e_deq   = 1'b0;
                e_rd    = en && !m_halted && !halt;
                e_addr  = tgt;
            end else begin
                e_valid = (m_q.size() != 0);
                e_deq   = e_valid && out_ready;
                e_rd    = en && !m_halted && !halt && ((m_q.size() - int'(e_deq)) <= 1);
                e_addr  = m_fetch;
            end
            chk("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
            if (e_valid) begin
                chk("out_pc", out_pc, m_q[0]);
                chk("out_pc_plus4", out_pc_plus4, m_q[0] + 32'd4);
                chk("out_inst", out_inst, memf(m_q[0]));
            end
            chk("imem_rd", {31'h0, imem_rd}, {31'h0, e_rd});
            if (e_rd) chk("imem_addr", imem_addr, e_addr);
            chk("halted", {31'h0, halted}, {31'h0, m_halted});
            if (redirect_valid) begin
                m_q.delete();
                m_fetch = e_rd ? tgt + 32'd4 : tgt;
                if (e_rd) m_q.push_back(tgt);
            end else begin
                if (e_deq) void'(m_q.pop_front());
                if (e_rd) begin
                    m_q.push_back(m_fetch);
                    m_fetch = m_fetch + 32'd4;
                end
            end
            if (halt) m_halted = 1'b1;
        end
        mem_rd_n   = imem_rd;
        mem_addr_n = imem_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rd_cnt;
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) step();

        // Streaming from reset; wrap instance runs alongside.
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("c0_valid", {31'h0, out_valid}, 32'h0);
        chk("c0_rd", {31'h0, imem_rd}, 32'h1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("w0_addr", w_imem_addr, 32'hFFFF_FFF8);
        step(); @(negedge clk);
        chk("c1_valid", {31'h0, out_valid}, 32'h1);
        chk("c1_pc", out_pc, 32'h0);
        chk("c1_pc4", out_pc_plus4, 32'h4);
        chk("c1_inst", out_inst, 32'hC0DE_0000);
        chk("w1_pc", w_out_pc, 32'hFFFF_FFF8);
        step(); @(negedge clk);
        chk("c2_pc", out_pc, 32'h4);
        chk("w2_pc", w_out_pc, 32'hFFFF_FFFC);
        chk("w2_pc4", w_out_pc_plus4, 32'h0);
        step(); out_ready = 1'b0; rd_cnt = 0;

        // Back-pressure for five cycles at pc 8.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) chk("w3_pc", w_out_pc, 32'h0);
            chk("bp_pc", out_pc, 32'h8);
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
            rd_cnt += int'(imem_rd);
            step();
        end
        chk("bp_reads_le2", {31'h0, rd_cnt <= 2}, 32'h1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rel_pc", out_pc, 32'h8 + 32'(4 * k));
            step();
        end

        // Fill the buffer, then redirect.
        out_ready = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 32'h103; out_ready = 1'b1;
        @(negedge clk);
        chk("rd_valid", {31'h0, out_valid}, 32'h0);
        chk("rd_rd", {31'h0, imem_rd}, 32'h1);
        chk("rd_addr", imem_addr, 32'h100);
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd1_pc", out_pc, 32'h100);
        chk("rd1_inst", out_inst, 32'hC0DE_0040);
        step(); out_ready = 1'b0;
        @(negedge clk);
        chk("rd2_pc", out_pc, 32'h104);

        // Halt with one buffered and one in flight.
        step(); halt = 1'b1;
        @(negedge clk);
        chk("h_rd", {31'h0, imem_rd}, 32'h0);
        chk("h_pc", out_pc, 32'h104);
        step(); halt = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("h1_halted", {31'h0, halted}, 32'h1);
        chk("h1_pc", out_pc, 32'h104);
        step(); @(negedge clk);
        chk("h2_pc", out_pc, 32'h108);
        step(); @(negedge clk);
        chk("h3_valid", {31'h0, out_valid}, 32'h0);
        chk("h3_rd", {31'h0, imem_rd}, 32'h0);
        step(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        chk("h4_rd", {31'h0, imem_rd}, 32'h0);
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("h5_valid", {31'h0, out_valid}, 32'h0);
        chk("h5_halted", {31'h0, halted}, 32'h1);

        // Mid-operation reset with a buffered entry.
        step(); rst = 1'b1;
        step(); rst = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_valid", {31'h0, out_valid}, 32'h0);
        step(); rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mr1_valid", {31'h0, out_valid}, 32'h0);
        chk("mr1_addr", imem_addr, 32'h0);
        chk("mr1_rd", {31'h0, imem_rd}, 32'h1);
        step(); @(negedge clk);
        chk("mr2_pc", out_pc, 32'h0);
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 59) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                         : ($urandom & 32'h0000_0FFF);
            halt           = ($urandom_range(0, 39) == 0);
            en             = ($urandom_range(0, 7) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            step();
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
